br_resolve_queue: RTL and testbench

BR_RESOLVE_QUEUE -- requirements
Module: br_resolve_queue

---
 rtl/br_resolve_queue.sv | 165 ++++++++++++++++
 tb/tb_br_resolve_queue.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/br_resolve_queue.sv
// br_resolve_queue: in-order queue of predicted branches awaiting resolution.
// Fetch pushes each predicted branch. Execute resolves the oldest entry, which
// produces a predictor-update pulse and, on a wrong prediction, a fetch
// redirect that discards all younger (wrong-path) entries.
// Optional feature macro: BR_RESOLVE_STATS_EN adds live br_cnt / miss_cnt
// counters. When it is undefined, both ports exist and read as zero.
// Handshake: push and resolve are single-cycle strobes with no ready signal.
// Occupancy is reported through full/empty/count. A push while full (with no
// pop) is dropped and flagged by overflow. A resolve while empty is dropped and
// flagged by underflow.
module br_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 4
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       push,
  input  logic [IDX_W-1:0]           push_index,
  input  logic                       push_predict,
  input  logic [31:0]                push_target,
  input  logic [31:0]                push_npc,
  input  logic                       resolve,
  input  logic                       resolve_taken,
  input  logic [31:0]                resolve_target,
  input  logic                       flush,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       upd_br,
  output logic [IDX_W-1:0]           upd_index,
  output logic                       upd_taken,
  output logic [31:0]                upd_target,
  output logic                       mispredict,
  output logic [31:0]                redirect_pc,
  output logic                       overflow,
  output logic                       underflow,
  output logic [31:0]                br_cnt,
  output logic [31:0]                miss_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Entry storage, one slot per in-flight branch
  logic [IDX_W-1:0] r_idx  [DEPTH];
  logic             r_pred [DEPTH];
  logic [31:0]      r_tgt  [DEPTH];
  logic [31:0]      r_npc  [DEPTH];

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic             w_full;
  logic             w_empty;
  logic             w_res_acc;
  logic             w_mis;
  logic             w_push_acc;
  logic             w_ovf;
  logic             w_udf;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  assign full    = w_full;
  assign empty   = w_empty;
  assign count   = r_count;

  // A resolve is taken only if there is something to pop and no flush wins
  assign w_res_acc = resolve & ~w_empty & ~flush;

  // Direction wrong, or taken-taken with a stale target
  assign w_mis = (r_pred[r_head] != resolve_taken) |
                 (r_pred[r_head] & resolve_taken & (r_tgt[r_head] != resolve_target));

  // A push survives unless flushed, squashed by a mispredict, or blocked by full
  assign w_push_acc = push & ~flush & ~(w_res_acc & w_mis) & (~w_full | w_res_acc);

  // Error pulses: a resolve on a full queue always frees a slot, so only a lone push overflows
  assign w_ovf = push & w_full & ~resolve & ~flush;
  assign w_udf = resolve & w_empty & ~flush;

  // Write the pushed branch into the tail slot; reset clears every slot
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_idx[i]  <= '0;
        r_pred[i] <= 1'b0;
        r_tgt[i]  <= '0;
        r_npc[i]  <= '0;
      end
    end else if (w_push_acc) begin
      r_idx[r_tail]  <= push_index;
      r_pred[r_tail] <= push_predict;
      r_tgt[r_tail]  <= push_target;
      r_npc[r_tail]  <= push_npc;
    end
  end

  // Pointer/count bookkeeping and the registered resolve/error pulses
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      upd_br      <= 1'b0;
      upd_index   <= '0;
      upd_taken   <= 1'b0;
      upd_target  <= '0;
      mispredict  <= 1'b0;
      redirect_pc <= '0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      upd_br     <= 1'b0;
      mispredict <= 1'b0;
      overflow   <= w_ovf;
      underflow  <= w_udf;

      if (flush || (w_res_acc && w_mis)) begin
        // Everything queued is gone: flush, or wrong-path behind a mispredict
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_res_acc)  r_head <= r_head + 1'b1;
        if (w_push_acc) r_tail <= r_tail + 1'b1;
        r_count <= r_count + CNT_W'(w_push_acc) - CNT_W'(w_res_acc);
      end

      if (w_res_acc) begin
        upd_br     <= 1'b1;
        upd_index  <= r_idx[r_head];
        upd_taken  <= resolve_taken;
        upd_target <= resolve_target;
        if (w_mis) begin
          mispredict  <= 1'b1;
          redirect_pc <= resolve_taken ? resolve_target : r_npc[r_head];
        end
      end
    end
  end

`ifdef BR_RESOLVE_STATS_EN
  logic [31:0] r_br_cnt;
  logic [31:0] r_miss_cnt;

  // Lifetime statistics; only reset clears them, flush does not
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_br_cnt   <= '0;
      r_miss_cnt <= '0;
    end else if (w_res_acc) begin
      r_br_cnt <= r_br_cnt + 32'd1;
      if (w_mis) r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign br_cnt   = r_br_cnt;
  assign miss_cnt = r_miss_cnt;
`else
  assign br_cnt   = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_br_resolve_queue.sv
// tb_br_resolve_queue: directed scenarios plus randomized traffic for
// br_resolve_queue, compared each cycle against a queue-based reference model.
// When BR_RESOLVE_STATS_EN is defined, the model also tracks the statistics
// counters. Otherwise it expects br_cnt and miss_cnt to read zero.
module tb_br_resolve_queue;

  localparam int DEPTH = 4;
  localparam int IDX_W = 4;

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic             pred;
    logic [31:0]      tgt;
    logic [31:0]      npc;
  } ent_t;

  logic              CLK;
  logic              nRST;
  logic              push;
  logic [IDX_W-1:0]  push_index;
  logic              push_predict;
  logic [31:0]       push_target;
  logic [31:0]       push_npc;
  logic              resolve;
  logic              resolve_taken;
  logic [31:0]       resolve_target;
  logic              flush;
  logic              full;
  logic              empty;
  logic [2:0]        count;
  logic              upd_br;
  logic [IDX_W-1:0]  upd_index;
  logic              upd_taken;
  logic [31:0]       upd_target;
  logic              mispredict;
  logic [31:0]       redirect_pc;
  logic              overflow;
  logic              underflow;
  logic [31:0]       br_cnt;
  logic [31:0]       miss_cnt;

  br_resolve_queue #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .CLK(CLK), .nRST(nRST),
    .push(push), .push_index(push_index), .push_predict(push_predict),
    .push_target(push_target), .push_npc(push_npc),
    .resolve(resolve), .resolve_taken(resolve_taken), .resolve_target(resolve_target),
    .flush(flush),
    .full(full), .empty(empty), .count(count),
    .upd_br(upd_br), .upd_index(upd_index), .upd_taken(upd_taken), .upd_target(upd_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .overflow(overflow), .underflow(underflow),
    .br_cnt(br_cnt), .miss_cnt(miss_cnt)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- reference model state ----------------
  ent_t        exp_q[$];
  logic        e_upd_br, e_upd_taken, e_mis, e_ovf, e_udf;
  logic [3:0]  e_upd_index;
  logic [31:0] e_upd_target, e_redir, e_br, e_miss;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    exp_q.delete();
    e_upd_br = 0; e_upd_taken = 0; e_mis = 0; e_ovf = 0; e_udf = 0;
    e_upd_index = 0; e_upd_target = 0; e_redir = 0; e_br = 0; e_miss = 0;
  endfunction

  // One clock of behaviour: pop oldest if resolving, a wrong guess kills all
  // younger work and the same-cycle push, otherwise append if room.
  function automatic void model_step(
      input logic p, input logic [3:0] pi, input logic pp, input logic [31:0] pt,
      input logic [31:0] pn, input logic r, input logic rt, input logic [31:0] rtg,
      input logic f);
    int   sz;
    logic res_ok, mis;
    ent_t h, n;
    e_upd_br = 0; e_mis = 0; e_ovf = 0; e_udf = 0;
    if (f) begin
      exp_q.delete();
      return;
    end
    sz     = exp_q.size();
    res_ok = r && (sz > 0);
    mis    = 0;
    if (r && sz == 0) e_udf = 1;
    if (res_ok) begin
      h = exp_q.pop_front();
      mis = (h.pred != rt) || (h.pred && rt && (h.tgt != rtg));
      e_upd_br = 1; e_upd_index = h.idx; e_upd_taken = rt; e_upd_target = rtg;
`ifdef BR_RESOLVE_STATS_EN
      e_br++;
      if (mis) e_miss++;
`endif
      if (mis) begin
        e_mis = 1;
        e_redir = rt ? rtg : h.npc;
        exp_q.delete();
      end
    end
    if (p && !mis) begin
      if (sz == DEPTH && !res_ok) e_ovf = 1;
      else begin
        n.idx = pi; n.pred = pp; n.tgt = pt; n.npc = pn;
        exp_q.push_back(n);
      end
    end
  endfunction

  task automatic check_all();
    check_eq("count",       32'(count),      32'(exp_q.size()));
    check_eq("empty",       32'(empty),      32'(exp_q.size() == 0));
    check_eq("full",        32'(full),       32'(exp_q.size() == DEPTH));
    check_eq("upd_br",      32'(upd_br),     32'(e_upd_br));
    check_eq("upd_index",   32'(upd_index),  32'(e_upd_index));
    check_eq("upd_taken",   32'(upd_taken),  32'(e_upd_taken));
    check_eq("upd_target",  upd_target,      e_upd_target);
    check_eq("mispredict",  32'(mispredict), 32'(e_mis));
    check_eq("redirect_pc", redirect_pc,     e_redir);
    check_eq("overflow",    32'(overflow),   32'(e_ovf));
    check_eq("underflow",   32'(underflow),  32'(e_udf));
    check_eq("br_cnt",      br_cnt,          e_br);
    check_eq("miss_cnt",    miss_cnt,        e_miss);
  endtask

  // ---------------- driver ----------------
  task automatic step(
      input logic p, input logic [3:0] pi, input logic pp, input logic [31:0] pt,
      input logic [31:0] pn, input logic r, input logic rt, input logic [31:0] rtg,
      input logic f);
    @(negedge CLK);
    push = p; push_index = pi; push_predict = pp; push_target = pt; push_npc = pn;
    resolve = r; resolve_taken = rt; resolve_target = rtg; flush = f;
    @(posedge CLK);
    model_step(p, pi, pp, pt, pn, r, rt, rtg, f);
    #1;
    check_all();
  endtask

  task automatic do_push(input logic [3:0] pi, input logic pp, input logic [31:0] pt, input logic [31:0] pn);
    step(1, pi, pp, pt, pn, 0, 0, 0, 0);
  endtask

  task automatic do_resolve(input logic rt, input logic [31:0] rtg);
    step(0, 0, 0, 0, 0, 1, rt, rtg, 0);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    push = 0; push_index = 0; push_predict = 0; push_target = 0; push_npc = 0;
    resolve = 0; resolve_taken = 0; resolve_target = 0; flush = 0;
    nRST = 0;
    model_reset();
    #12;
    check_all();
    @(negedge CLK);
    nRST = 1;
    idle();

    // correct taken prediction
    do_push(4'd3, 1, 32'h100, 32'h44);
    do_resolve(1, 32'h100);
    check_eq("t1_upd_br",  32'(upd_br), 32'd1);
    check_eq("t1_idx",     32'(upd_index), 32'd3);
    check_eq("t1_mis",     32'(mispredict), 32'd0);
    idle();
    check_eq("t1_pulse_once", 32'(upd_br), 32'd0);

    // direction mispredict squashes younger entries
    do_push(4'd5, 0, 32'h0, 32'h20);
    do_push(4'd6, 0, 32'h0, 32'h24);
    do_push(4'd7, 0, 32'h0, 32'h28);
    do_resolve(1, 32'h80);
    check_eq("t2_mis",   32'(mispredict), 32'd1);
    check_eq("t2_redir", redirect_pc, 32'h80);
    check_eq("t2_empty", 32'(empty), 32'd1);
    idle();
    check_eq("t2_redir_hold", redirect_pc, 32'h80);

    // target mispredict, then direction mispredict to fall-through
    do_push(4'd1, 1, 32'h200, 32'h10);
    do_resolve(1, 32'h300);
    check_eq("t3_redir_tgt", redirect_pc, 32'h300);
    do_push(4'd1, 1, 32'h200, 32'h10);
    do_resolve(0, 32'h0);
    check_eq("t3_redir_npc", redirect_pc, 32'h10);

    // fill, overflow, then push+resolve across pointer wrap
    for (int i = 0; i < 4; i++) do_push(4'(i), 0, 32'h0, 32'h40 + 32'(i));
    do_push(4'd9, 0, 32'h0, 32'h99);
    check_eq("t4_ovf",   32'(overflow), 32'd1);
    check_eq("t4_count", 32'(count), 32'd4);
    for (int i = 0; i < 6; i++) begin
      step(1, 4'(8 + i), 0, 32'h0, 32'h50, 1, 0, 32'h0, 0);
      check_eq("t4_wrap_ovf", 32'(overflow), 32'd0);
    end
    check_eq("t4_order", 32'(upd_index), 32'd9);
    for (int i = 0; i < 4; i++) do_resolve(0, 32'h0);
    check_eq("t4_drained", 32'(empty), 32'd1);

    // underflow, then flush overriding push+resolve
    do_resolve(1, 32'h0);
    check_eq("t5_udf",    32'(underflow), 32'd1);
    check_eq("t5_no_upd", 32'(upd_br), 32'd0);
    do_push(4'd2, 1, 32'h60, 32'h64);
    step(1, 4'd4, 0, 32'h0, 32'h70, 1, 0, 32'h0, 1);
    check_eq("t5_flush_empty", 32'(empty), 32'd1);
    check_eq("t5_flush_noupd", 32'(upd_br), 32'd0);

    // asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) do_push(4'(i), 1, 32'h100, 32'h8);
    @(negedge CLK);
    push = 0; resolve = 0; flush = 0;
    #2 nRST = 0;
    model_reset();
    #1;
    check_all();
    @(negedge CLK);
    nRST = 1;
    idle();

    // ten resolves, three of them mispredicted
    for (int i = 0; i < 10; i++) begin
      do_push(4'(i), 1, 32'h100, 32'h8);
      do_resolve(1, (i < 3) ? 32'h104 : 32'h100);
    end
`ifdef BR_RESOLVE_STATS_EN
    check_eq("stats_br",   br_cnt,   32'd10);
    check_eq("stats_miss", miss_cnt, 32'd3);
`else
    check_eq("stats_br_tied",   br_cnt,   32'd0);
    check_eq("stats_miss_tied", miss_cnt, 32'd0);
`endif

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic p, pp, r, rt, f;
      logic [31:0] pt, rtg;
      p   = ($urandom_range(2, 0) != 0);
      pp  = 1'($urandom_range(1, 0));
      pt  = ($urandom_range(1, 0) != 0) ? 32'h100 : 32'h200;
      r   = 1'($urandom_range(1, 0));
      rt  = ($urandom_range(3, 0) != 0) ? pp : ~pp;
      rtg = ($urandom_range(3, 0) != 0) ? pt : 32'h300;
      f   = ($urandom_range(24, 0) == 0);
      step(p, 4'($urandom_range(15, 0)), pp, pt, $urandom(), r, rt, rtg, f);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
